sync_arith_unit_seq: RTL and testbench

- Parametrised, handshaked successor of the 4-bit synchronous arithmetic unit. Width is generic (M bits), and the op field widens to 3 bits.
- Adds a multi-cycle unsigned shift-add multiply and a valid/ready handshake.
- Status flags now have defined meanings: zero, negative, overflow, illegal-op.
- Sits between the operand register file and the result bus. One transaction in flight.

---
 rtl/sync_arith_unit_seq.sv | 132 +++++++++++++
 tb/tb_sync_arith_unit_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_arith_unit_seq.sv
// Handshaked M-bit arithmetic unit: single-cycle SUB/COMP/SUM/CONV plus an
// M-cycle unsigned shift-add MUL. One transaction in flight; results and flags registered.
module sync_arith_unit_seq #(
  parameter  int M  = 8,
  parameter  int N  = 3,
  localparam int IW = $clog2(M)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_valid,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  localparam logic [N-1:0] OP_SUB  = 3'b000;
  localparam logic [N-1:0] OP_COMP = 3'b001;
  localparam logic [N-1:0] OP_SUM  = 3'b010;
  localparam logic [N-1:0] OP_CONV = 3'b011;
  localparam logic [N-1:0] OP_MUL  = 3'b100;

  logic [0:0]     state;
  logic [IW-1:0]  mul_cnt;
  logic [M-1:0]   mul_a;
  // Product register: high half accumulates, low half starts as the multiplier.
  logic [2*M-1:0] mul_prod;
  logic [2*M-1:0] mul_prod_next;
  logic [M:0]     mul_sum;

  logic [M-1:0]   alu_res;
  logic           alu_v;
  logic           alu_e;

  logic [M+1:0]   sub_full;
  logic [M-1:0]   sum_s;
  logic [M-1:0]   sum_mask;
  logic [M-2:0]   conv_mag;

  assign o_ready = (state == S_IDLE);

  always_comb begin
    mul_sum       = {1'b0, mul_prod[2*M-1:M]} + {1'b0, (mul_prod[0] ? mul_a : {M{1'b0}})};
    mul_prod_next = {mul_sum, mul_prod[M-1:1]};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    alu_res = '0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;

    // A - 2B in M+2 bits: wide enough to hold the exact value for all operands.
    sub_full = {{2{i_arg_A[M-1]}}, i_arg_A} - {i_arg_B[M-1], i_arg_B, 1'b0};
    sum_s    = i_arg_A + i_arg_B;
    sum_mask = {{(M-1){1'b0}}, 1'b1} << i_arg_B[IW-1:0];
    conv_mag = (~i_arg_A[M-2:0]) + {{(M-2){1'b0}}, 1'b1};

    case (i_op)
      OP_SUB: begin
        alu_res = sub_full[M-1:0];
        alu_v   = !((sub_full[M+1:M-1] == '0) || (sub_full[M+1:M-1] == '1));
      end
      OP_COMP: begin
        alu_res = {{(M-1){1'b0}}, ($signed(i_arg_A) < $signed(i_arg_B))};
      end
      OP_SUM: begin
        alu_res = sum_s & ~sum_mask;
        alu_v   = (i_arg_A[M-1] == i_arg_B[M-1]) && (sum_s[M-1] != i_arg_A[M-1]);
      end
      OP_CONV: begin
        // The most negative value has no magnitude; it maps onto itself with V set.
        alu_res = i_arg_A[M-1] ? {1'b1, conv_mag} : i_arg_A;
        alu_v   = i_arg_A[M-1] && (i_arg_A[M-2:0] == '0);
      end
      default: begin
        alu_e = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state    <= S_IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
      mul_cnt  <= '0;
      mul_a    <= '0;
      mul_prod <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (i_op == OP_MUL) begin
              mul_a    <= i_arg_A;
              mul_prod <= {{M{1'b0}}, i_arg_B};
              mul_cnt  <= '0;
              state    <= S_MUL_RUN;
            end else begin
              o_result <= alu_res;
              o_status <= {alu_e, alu_v, alu_res[M-1], (alu_res == '0)};
              o_valid  <= 1'b1;
            end
          end
        end
        default: begin
          mul_prod <= mul_prod_next;
          mul_cnt  <= mul_cnt + 1'b1;
          if (mul_cnt == IW'(M - 1)) begin
            o_result <= mul_prod_next[M-1:0];
            o_status <= {1'b0, (mul_prod_next[2*M-1:M] != '0),
                         mul_prod_next[M-1], (mul_prod_next[M-1:0] == '0)};
            o_valid  <= 1'b1;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_arith_unit_seq.sv
// Self-checking bench for sync_arith_unit_seq (M=8): directed vectors plus
// randomized operations checked against an integer-arithmetic reference model.
module tb_sync_arith_unit_seq;
  localparam int M = 8;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [M-1:0] i_arg_A;
  logic [M-1:0] i_arg_B;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  sync_arith_unit_seq #(.M(M)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_arg_A(i_arg_A), .i_arg_B(i_arg_B),
    .o_valid(o_valid), .o_result(o_result), .o_status(o_status)
  );

  // Reference model from the arithmetic rules: returns {status, result}.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, t;
    int unsigned p;
    logic [7:0] res;
    logic v, e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 8'h00; v = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin t = sa - 2 * sb; res = 8'(t); v = (t < -128) || (t > 127); end
      3'd1: res = (sa < sb) ? 8'd1 : 8'd0;
      3'd2: begin
        t = sa + sb; v = (t < -128) || (t > 127);
        res = 8'((int'(a) + int'(b)) % 256) & ~8'(1 << (int'(b) % 8));
      end
      3'd3: begin
        if (sa >= 0) res = a;
        else if (sa == -128) begin res = 8'h80; v = 1'b1; end
        else res = 8'h80 | 8'(-sa);
      end
      3'd4: begin p = int'(a) * int'(b); res = 8'(p % 256); v = (p > 255); end
      default: e = 1'b1;
    endcase
    return {e, v, res[7], (res == 8'h00), res};
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_op = '0; i_arg_A = '0; i_arg_B = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge i_clk); #1;
      n_checks++;
      if ({o_valid, o_ready, o_status, o_result} !== {1'b0, 1'b1, 4'h0, 8'h00})
        $display("FAIL reset[%0d]: got v=%b rdy=%b st=%b res=%h, expected v=0 rdy=1 st=0000 res=00",
                 c, o_valid, o_ready, o_status, o_result);
      else n_pass++;
    end
    i_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      n_checks++;
      if ({o_valid, o_ready, o_status, o_result} !== {1'b0, 1'b1, 4'h0, 8'h00})
        $display("FAIL idle[%0d]: got v=%b rdy=%b st=%b res=%h, expected v=0 rdy=1 st=0000 res=00",
                 c, o_valid, o_ready, o_status, o_result);
      else n_pass++;
    end
  endtask

  // Directed single-cycle vectors issued on consecutive edges.
  task automatic test_single_cycle();
    logic [2:0] t_op [9]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
    logic [7:0] t_a  [9]  = '{8'd20, 8'h9C, 8'hFE, 8'h05, 8'h1C, 8'h7F, 8'hFD, 8'h80, 8'h05};
    logic [7:0] t_b  [9]  = '{8'd3, 8'd30, 8'h01, 8'hFB, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0] t_res[9]  = '{8'h0E, 8'h60, 8'h01, 8'h00, 8'h1A, 8'h80, 8'h83, 8'h80, 8'h05};
    logic [3:0] t_st [9]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0110,
                              4'b0010, 4'b0110, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      i_valid = 1'b1; i_op = t_op[i]; i_arg_A = t_a[i]; i_arg_B = t_b[i];
      @(posedge i_clk); #1;
      n_checks++;
      if ({o_valid, o_status, o_result} !== {1'b1, t_st[i], t_res[i]})
        $display("FAIL single[%0d] op=%0d: got v=%b st=%b res=%h, expected v=1 st=%b res=%h",
                 i, t_op[i], o_valid, o_status, o_result, t_st[i], t_res[i]);
      else n_pass++;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_mul();
    logic [7:0] t_a  [2] = '{8'd13, 8'h20};
    logic [7:0] t_b  [2] = '{8'd11, 8'h10};
    logic [7:0] t_res[2] = '{8'h8F, 8'h00};
    logic [3:0] t_st [2] = '{4'b0010, 4'b0101};
    logic bad;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_op = 3'd4; i_arg_A = t_a[i]; i_arg_B = t_b[i];
      @(posedge i_clk); #1;
      // A SUB held on the inputs while busy must be ignored.
      i_op = 3'd0; i_arg_A = 8'd20; i_arg_B = 8'd3;
      bad = 1'b0;
      for (int c = 1; c < M; c++) begin
        if (o_ready !== 1'b0 || o_valid !== 1'b0) bad = 1'b1;
        @(posedge i_clk); #1;
      end
      if (o_ready !== 1'b0 || o_valid !== 1'b0) bad = 1'b1;
      n_checks++;
      if (bad) $display("FAIL mul_busy[%0d]: got ready/valid activity during run, expected ready=0 valid=0", i);
      else n_pass++;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n_checks++;
      if ({o_valid, o_ready, o_status, o_result} !== {1'b1, 1'b1, t_st[i], t_res[i]})
        $display("FAIL mul[%0d]: got v=%b rdy=%b st=%b res=%h, expected v=1 rdy=1 st=%b res=%h",
                 i, o_valid, o_ready, o_status, o_result, t_st[i], t_res[i]);
      else n_pass++;
      @(posedge i_clk); #1;
      n_checks++;
      if ({o_valid, o_result} !== {1'b0, t_res[i]})
        $display("FAIL mul_after[%0d]: got v=%b res=%h, expected v=0 res=%h",
                 i, o_valid, o_result, t_res[i]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    i_valid = 1'b1; i_op = 3'b110; i_arg_A = 8'h5A; i_arg_B = 8'h33;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_status, o_result} !== {1'b1, 4'b1001, 8'h00})
      $display("FAIL illegal: got v=%b st=%b res=%h, expected v=1 st=1001 res=00",
               o_valid, o_status, o_result);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic bad;
    i_valid = 1'b1; i_op = 3'd1; i_arg_A = 8'hFE; i_arg_B = 8'h01;
    @(posedge i_clk); #1;
    n_checks++;
    if ({o_valid, o_result} !== {1'b1, 8'h01})
      $display("FAIL pre_abort: got v=%b res=%h, expected v=1 res=01", o_valid, o_result);
    else n_pass++;
    i_op = 3'd4; i_arg_A = 8'd13; i_arg_B = 8'd11;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    n_checks++;
    if ({o_valid, o_ready, o_status, o_result} !== {1'b0, 1'b1, 4'h0, 8'h00})
      $display("FAIL abort: got v=%b rdy=%b st=%b res=%h, expected v=0 rdy=1 st=0000 res=00",
               o_valid, o_ready, o_status, o_result);
    else n_pass++;
    bad = 1'b0;
    repeat (M) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL abort_quiet: got o_valid=1 after aborted MUL, expected 0");
    else n_pass++;
    i_valid = 1'b1; i_op = 3'd2; i_arg_A = 8'd3; i_arg_B = 8'd5;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_status, o_result} !== {1'b1, 4'b0000, 8'h08})
      $display("FAIL post_abort_sum: got v=%b st=%b res=%h, expected v=1 st=0000 res=08",
               o_valid, o_status, o_result);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [11:0] exp;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      exp = model(op, a, b);
      i_valid = 1'b1; i_op = op; i_arg_A = a; i_arg_B = b;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      if (op == 3'd4) repeat (M) begin @(posedge i_clk); #1; end
      n_checks++;
      if ({o_valid, o_status, o_result} !== {1'b1, exp})
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got v=%b st=%b res=%h, expected v=1 st=%b res=%h",
                 i, op, a, b, o_valid, o_status, o_result, exp[11:8], exp[7:0]);
      else n_pass++;
    end
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_op = '0; i_arg_A = '0; i_arg_B = '0;
    @(posedge i_clk); #1;
    test_reset();
    test_single_cycle();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
